// File: rtl/seller_pkg.sv
// Shared types, coin unit constants and coin decoding for the multi-product seller.
package seller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2
  } state_e;

  localparam logic [2:0] COIN_UNIT_HALF = 3'd1;
  localparam logic [2:0] COIN_UNIT_ONE  = 3'd2;
  localparam logic [2:0] COIN_UNIT_TWO  = 3'd4;

  typedef struct packed {
    logic       present;
    logic       legal;
    logic [2:0] units;
  } coin_dec_t;

  // A coin is legal only when exactly one denomination bit is set.
  function automatic coin_dec_t coin_decode(input logic [2:0] coin);
    coin_dec_t d;
    d.present = |coin;
    d.legal   = 1'b0;
    d.units   = 3'd0;
    case (coin)
      3'b001: begin d.legal = 1'b1; d.units = COIN_UNIT_HALF; end
      3'b010: begin d.legal = 1'b1; d.units = COIN_UNIT_ONE;  end
      3'b100: begin d.legal = 1'b1; d.units = COIN_UNIT_TWO;  end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seller_multi_if.sv
// Customer-side bus of the seller: coin/select/cancel in, dispense/refund/credit out.
interface seller_multi_if #(
  parameter int CRED_W = 4
);
  logic [2:0]        coin;
  logic              sel_vld;
  logic [2:0]        sel;
  logic              cancel;
  logic              out_vld;
  logic [2:0]        out_prod;
  logic [CRED_W-1:0] change;
  logic              refund_vld;
  logic              coin_rej;
  logic [CRED_W-1:0] credit;

  modport master (
    output coin, sel_vld, sel, cancel,
    input  out_vld, out_prod, change, refund_vld, coin_rej, credit
  );

  modport slave (
    input  coin, sel_vld, sel, cancel,
    output out_vld, out_prod, change, refund_vld, coin_rej, credit
  );
endinterface

// File: rtl/seller_price_sel.sv
// Combinational price lookup for the selected product plus range check of the index.
module seller_price_sel #(
  parameter int                        NPROD   = 2,
  parameter int                        PRICE_W = 4,
  parameter logic [NPROD*PRICE_W-1:0]  PRICES  = {4'd5, 4'd3}
) (
  input  logic [2:0]         sel,
  output logic [PRICE_W-1:0] price,
  output logic               in_range
);

  always_comb begin
    price    = '0;
    in_range = 1'b0;
    for (int i = 0; i < NPROD; i++) begin
      if (32'(sel) == i) begin
        price    = PRICES[i*PRICE_W +: PRICE_W];
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seller_multi.sv
// Multi-product vending seller: accumulates coins, dispenses with change.
// Optional refund on cancel is enabled by defining SELLER_CANCEL_EN.
module seller_multi
  import seller_pkg::*;
#(
  parameter int                       NPROD   = 2,
  parameter int                       PRICE_W = 4,
  parameter logic [NPROD*PRICE_W-1:0] PRICES  = {4'd5, 4'd3},
  parameter int                       CRED_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  seller_multi_if.slave  bus
);

  localparam int                CMP_W      = (CRED_W > PRICE_W) ? CRED_W : PRICE_W;
  localparam logic [CRED_W-1:0] CREDIT_MAX = '1;

  state_e            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W-1:0] change_q, change_d;
  logic [2:0]        out_prod_q, out_prod_d;
  logic              out_vld_q, out_vld_d;
  logic              refund_vld_q, refund_vld_d;
  logic              coin_rej_q, coin_rej_d;

  logic [PRICE_W-1:0] price;
  logic               in_range;
  logic               cancel_req;
  coin_dec_t          cdec;
  logic [CRED_W:0]    sum;
  logic               coin_ok;
  logic [CRED_W-1:0]  credit_eff;
  logic               afford;

  seller_price_sel #(
    .NPROD   (NPROD),
    .PRICE_W (PRICE_W),
    .PRICES  (PRICES)
  ) u_price_sel (
    .sel      (bus.sel),
    .price    (price),
    .in_range (in_range)
  );

`ifdef SELLER_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_req    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    change_d     = '0;
    out_prod_d   = '0;
    out_vld_d    = 1'b0;
    refund_vld_d = 1'b0;
    coin_rej_d   = 1'b0;

    // Selection is judged against credit that already includes a same-cycle coin.
    cdec       = coin_decode(bus.coin);
    sum        = {1'b0, credit_q} + (CRED_W+1)'(cdec.units);
    coin_ok    = cdec.present && cdec.legal && (sum <= {1'b0, CREDIT_MAX});
    credit_eff = coin_ok ? sum[CRED_W-1:0] : credit_q;
    afford     = CMP_W'(credit_eff) >= CMP_W'(price);

    case (state_q)
      DISPENSE: begin
        coin_rej_d = cdec.present;
        credit_d   = '0;
        state_d    = IDLE;
      end
      default: begin
        if (cancel_req) begin
          refund_vld_d = 1'b1;
          change_d     = credit_q;
          coin_rej_d   = cdec.present;
          credit_d     = '0;
          state_d      = IDLE;
        end else begin
          coin_rej_d = cdec.present && !coin_ok;
          if (bus.sel_vld && in_range && afford) begin
            out_vld_d  = 1'b1;
            out_prod_d = bus.sel;
            change_d   = credit_eff - CRED_W'(price);
            credit_d   = '0;
            state_d    = DISPENSE;
          end else begin
            credit_d = credit_eff;
            state_d  = (credit_eff != '0) ? COLLECT : IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      change_q     <= '0;
      out_prod_q   <= '0;
      out_vld_q    <= 1'b0;
      refund_vld_q <= 1'b0;
      coin_rej_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      change_q     <= change_d;
      out_prod_q   <= out_prod_d;
      out_vld_q    <= out_vld_d;
      refund_vld_q <= refund_vld_d;
      coin_rej_q   <= coin_rej_d;
    end
  end

  assign bus.credit     = credit_q;
  assign bus.change     = change_q;
  assign bus.out_prod   = out_prod_q;
  assign bus.out_vld    = out_vld_q;
  assign bus.refund_vld = refund_vld_q;
  assign bus.coin_rej   = coin_rej_q;

endmodule
